// File: rtl/capture_buffer.sv
// Capture buffer: records DEPTH valid samples after start,
// then drains them over a valid/ready readout port.
module capture_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_vld,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_vld,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    READOUT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(DEPTH - 1);

  state_t state_q;
  state_t state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_nxt;

  logic hs;
  logic wr_en;
  logic last_wr;
  logic cnt_clr;
  logic cnt_inc;
  logic ld;

  always_comb begin
    state_d = state_q;
    hs      = rd_vld & rd_ready;
    wr_en   = (state_q == CAPTURE) & data_in_vld;
    last_wr = wr_en & (wr_ptr == LAST_ADDR);
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    ld      = 1'b0;
    rd_nxt  = hs ? rd_ptr + 1'b1 : rd_ptr;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAPTURE;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = data_in_vld;
        end
      end
      CAPTURE: begin
        if (last_wr) state_d = READOUT;
      end
      READOUT: begin
        cnt_inc = data_in_vld;
        ld      = ~rd_vld | (hs & ~rd_last);
        if (hs && rd_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
    end
  end

  // RAM has no reset so it can map onto block/distributed memory
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (state_q == IDLE && start) wr_ptr <= '0;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (last_wr) rd_ptr <= '0;
      else if (state_q == READOUT && hs) rd_ptr <= rd_nxt;
    end
  end

  // Output word is prefetched from rd_nxt so beats run back-to-back
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data <= '0;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == READOUT) begin
        if (hs && rd_last) begin
          rd_vld  <= 1'b0;
          rd_last <= 1'b0;
          done    <= 1'b1;
        end else if (ld) begin
          rd_data <= mem[rd_nxt];
          rd_vld  <= 1'b1;
          rd_last <= (rd_nxt == LAST_ADDR);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt <= '0;
    end else if (cnt_clr) begin
      drop_cnt <= '0;
    end else if (cnt_inc && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_capture_buffer.sv
// Scoreboard bench for capture_buffer: captured words are queued
// on write and compared against readout handshakes.
module tb_capture_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_in_vld = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_vld;
  logic          rd_ready = 1'b1;
  logic          rd_last;
  logic          busy;
  logic          done;
  logic [CW-1:0] drop_cnt;

  capture_buffer #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .data_in(data_in),
    .data_in_vld(data_in_vld),
    .start(start),
    .rd_data(rd_data),
    .rd_vld(rd_vld),
    .rd_ready(rd_ready),
    .rd_last(rd_last),
    .busy(busy),
    .done(done),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] sb[$];
  int beat_idx = 0;
  int done_cnt = 0;
  int exp_drop = 0;
  bit rdy_pat = 1'b0;
  int rcyc = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_pat) rd_ready = (rcyc % 4 == 0) || (rcyc % 4 == 3);
    else rd_ready = 1'b1;
    rcyc++;
  end

  logic          stall_q = 1'b0;
  logic [DW-1:0] data_q = '0;
  logic          last_q = 1'b0;
  logic [DW-1:0] exp_w;

  always @(negedge clk) begin
    if (!rstn) begin
      beat_idx = 0;
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_vld", 64'(rd_vld), 64'd1);
        chk("stall_data", 64'(rd_data), 64'(data_q));
        chk("stall_last", 64'(rd_last), 64'(last_q));
      end
      if (rd_vld && rd_ready) begin
        if (sb.size() == 0) begin
          chk("extra_beat", 64'd1, 64'd0);
        end else begin
          exp_w = sb.pop_front();
          chk("rd_data", 64'(rd_data), 64'(exp_w));
          chk("rd_last", 64'(rd_last),
              64'(beat_idx == DEPTH - 1));
        end
        beat_idx++;
      end
      stall_q = rd_vld && !rd_ready;
      data_q = rd_data;
      last_q = rd_last;
      if (done) begin
        chk("done_rd_vld", 64'(rd_vld), 64'd0);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_beats", 64'(beat_idx), 64'(DEPTH));
        chk("done_drop", 64'(drop_cnt), 64'(exp_drop));
        chk("done_sb_empty", 64'(sb.size()), 64'd0);
        done_cnt++;
        beat_idx = 0;
      end
    end
  end

  task automatic do_start(bit with_vld);
    start = 1'b1;
    data_in_vld = with_vld;
    data_in = 32'hdead_beef;
    tick();
    start = 1'b0;
    data_in_vld = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("drop_clr", 64'(drop_cnt), 64'd0);
  endtask

  task automatic capture(logic [DW-1:0] base, bit gapped,
                         int restart_at, int n);
    for (int i = 0; i < n; i++) begin
      if (gapped && i > 0) begin
        data_in_vld = 1'b0;
        data_in = 32'hbad0_0000;
        tick();
      end
      if (i == DEPTH - 1) begin
        chk("pre_last_no_vld", 64'(rd_vld), 64'd0);
        chk("pre_last_busy", 64'(busy), 64'd1);
      end
      start = (i == restart_at);
      data_in = base + DW'(i);
      data_in_vld = 1'b1;
      sb.push_back(base + DW'(i));
      tick();
      start = 1'b0;
    end
    data_in_vld = 1'b0;
  endtask

  task automatic readout(int drops, bit restart);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int t = 0; t < 2 && !seen; t++) begin
      data_in_vld = (n < drops);
      data_in = 32'hf00d_0000 + DW'(n);
      tick();
      n++;
      seen = rd_vld;
    end
    chk("first_vld_lat", 64'(seen), 64'd1);
    while (n < drops) begin
      data_in_vld = 1'b1;
      tick();
      n++;
    end
    data_in_vld = 1'b0;
    if (restart) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  task automatic wait_done(int budget);
    int d0;
    int c;
    d0 = done_cnt;
    c = 0;
    while (done_cnt == d0 && c < budget) begin
      tick();
      c++;
    end
    chk("done_seen", 64'(done_cnt != d0), 64'd1);
    repeat (4) tick();
    chk("single_done", 64'(done_cnt - d0), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_rd_vld"}, 64'(rd_vld), 64'd0);
    chk({tag, "_rd_last"}, 64'(rd_last), 64'd0);
    chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_drop"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    repeat (2) tick();
    chk_reset_vals("rst");
    rstn = 1'b1;
    tick();

    // basic; vld alongside start is neither captured nor counted
    exp_drop = 0;
    do_start(1'b1);
    capture(32'h1231, 1'b0, -1, DEPTH);
    readout(0, 1'b0);
    wait_done(60);

    // gapped input
    do_start(1'b0);
    capture(32'h1231, 1'b1, -1, DEPTH);
    readout(0, 1'b0);
    wait_done(60);

    // backpressure
    rdy_pat = 1'b1;
    do_start(1'b0);
    capture(32'h5000_0000, 1'b0, -1, DEPTH);
    readout(0, 1'b0);
    wait_done(150);
    rdy_pat = 1'b0;

    // drops in idle and during readout
    for (int i = 0; i < 5; i++) begin
      data_in_vld = 1'b1;
      data_in = 32'h0ddd_0000 + DW'(i);
      tick();
    end
    data_in_vld = 1'b0;
    chk("drop_idle", 64'(drop_cnt), 64'd5);
    exp_drop = 3;
    do_start(1'b0);
    capture(32'h7700_0000, 1'b0, -1, DEPTH);
    readout(3, 1'b0);
    wait_done(60);
    chk("drop_after_done", 64'(drop_cnt), 64'd3);

    // start ignored in capture and readout
    exp_drop = 0;
    do_start(1'b0);
    capture(32'h9900_0000, 1'b0, 5, DEPTH);
    readout(0, 1'b1);
    wait_done(60);

    // reset mid-capture
    do_start(1'b0);
    capture(32'ha000_0000, 1'b0, -1, 7);
    rstn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    sb.delete();
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_done_cnt", 64'(done), 64'd0);
    do_start(1'b0);
    capture(32'hb000_0000, 1'b0, -1, DEPTH);
    readout(0, 1'b0);
    wait_done(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
